// File: rtl/uart_rx_core.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_core
//  Description : Oversampling asynchronous serial receiver. Derives a bit
//                timebase from the system clock, majority-votes three samples
//                around each bit centre, checks optional parity and one or two
//                stop bits, and presents each frame through a one-entry
//                valid/ready holding register with parity, framing and
//                overrun status.
//
//  Ports       : clk         system clock
//                reset       synchronous, active-high reset
//                rx          asynchronous serial input, idle high
//                rx_ready    consumer accepts rx_data this cycle
//                rx_data     received payload, stable while rx_valid=1
//                rx_valid    holding register occupied
//                parity_err  parity mismatch for the frame in rx_data
//                frame_err   a stop-bit vote was 0 for the frame in rx_data
//                overrun     one-clk pulse: completed frame dropped
//                busy        receiver is not idle
//
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_core #(
    parameter int DATA_BITS  = 8,
    parameter int CLK_DIV    = 27,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    input  logic                 rx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int c_DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int c_SC_W  = $clog2(OVERSAMPLE);
    localparam int c_IDX_W = $clog2(DATA_BITS);
    localparam int c_HALF  = OVERSAMPLE / 2;

    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);
    localparam logic [c_SC_W-1:0]  c_SC_LO    = c_SC_W'(c_HALF - 1);
    localparam logic [c_SC_W-1:0]  c_SC_MID   = c_SC_W'(c_HALF);
    localparam logic [c_SC_W-1:0]  c_SC_DEC   = c_SC_W'(c_HALF + 1);
    localparam logic [c_SC_W-1:0]  c_SC_LAST  = c_SC_W'(OVERSAMPLE - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(DATA_BITS - 1);
    localparam logic               c_STOP_LAST = 1'(STOP_BITS - 1);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_START = 3'd1;
    localparam logic [2:0] c_ST_DATA  = 3'd2;
    localparam logic [2:0] c_ST_PAR   = 3'd3;
    localparam logic [2:0] c_ST_STOP  = 3'd4;
    localparam logic [2:0] c_ST_BREAK = 3'd5;

    // ------------------------------------------------------------------
    // Input synchronizer (resets to the idle line level)
    // ------------------------------------------------------------------
    logic r_rx_meta;
    logic r_rx_s;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    // ------------------------------------------------------------------
    // Oversample tick generator; free-running, only reset realigns it
    // ------------------------------------------------------------------
    logic [c_DIV_W-1:0] r_div;
    logic               w_tick;

    assign w_tick = (r_div == c_DIV_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_div <= '0;
        end else if (w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + c_DIV_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Receive state and datapath registers
    // ------------------------------------------------------------------
    logic [2:0]           r_state;
    logic [2:0]           w_state_next;
    logic [c_SC_W-1:0]    r_sc;
    logic [c_IDX_W-1:0]   r_bit_idx;
    logic                 r_stop_idx;
    logic                 r_stop_err;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_bit;
    logic                 r_vote0;
    logic                 r_vote1;

    logic w_sc_lo;
    logic w_sc_mid;
    logic w_sc_dec;
    logic w_sc_last;
    logic w_bit;
    logic w_stop_err;
    logic w_frame_done;
    logic w_par_err;

    assign w_sc_lo   = (r_sc == c_SC_LO);
    assign w_sc_mid  = (r_sc == c_SC_MID);
    assign w_sc_dec  = (r_sc == c_SC_DEC);
    assign w_sc_last = (r_sc == c_SC_LAST);

    // 2-of-3 vote: the first two samples were captured on earlier ticks,
    // the third is the live synchronized line at the decision tick.
    assign w_bit = (r_vote0 & r_vote1) | (r_vote0 & r_rx_s) | (r_vote1 & r_rx_s);

    assign w_stop_err = r_stop_err | ~w_bit;

    // The frame is complete at the last stop bit's decision point; the
    // remainder of that stop bit is not waited for so that a following
    // start edge is caught from IDLE.
    assign w_frame_done = w_tick && w_sc_dec && (r_state == c_ST_STOP) &&
                          (r_stop_idx == c_STOP_LAST);

    assign w_par_err = (PARITY == 0) ? 1'b0 :
                       (PARITY == 1) ? (r_par_bit != (^r_shift)) :
                                       (r_par_bit == (^r_shift));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_tick && !r_rx_s) begin
                    w_state_next = c_ST_START;
                end
            end
            c_ST_START: begin
                // A start bit that votes high was only a glitch.
                if (w_tick && w_sc_dec && w_bit) begin
                    w_state_next = c_ST_IDLE;
                end else if (w_tick && w_sc_last) begin
                    w_state_next = c_ST_DATA;
                end
            end
            c_ST_DATA: begin
                if (w_tick && w_sc_last && (r_bit_idx == c_IDX_LAST)) begin
                    w_state_next = (PARITY != 0) ? c_ST_PAR : c_ST_STOP;
                end
            end
            c_ST_PAR: begin
                if (w_tick && w_sc_last) begin
                    w_state_next = c_ST_STOP;
                end
            end
            c_ST_STOP: begin
                if (w_frame_done) begin
                    w_state_next = w_stop_err ? c_ST_BREAK : c_ST_IDLE;
                end
            end
            c_ST_BREAK: begin
                // Hold here through a line break so it yields one frame only.
                if (w_tick && r_rx_s) begin
                    w_state_next = c_ST_IDLE;
                end
            end
            default: begin
                w_state_next = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sc       <= '0;
            r_bit_idx  <= '0;
            r_stop_idx <= 1'b0;
            r_stop_err <= 1'b0;
            r_shift    <= '0;
            r_par_bit  <= 1'b0;
            r_vote0    <= 1'b1;
            r_vote1    <= 1'b1;
        end else if (w_tick) begin
            // IDLE pins the sample counter at 0 so a detected start edge
            // begins its bit period from a known phase.
            if ((r_state == c_ST_IDLE) || w_sc_last) begin
                r_sc <= '0;
            end else begin
                r_sc <= r_sc + c_SC_W'(1);
            end

            if (w_sc_lo) begin
                r_vote0 <= r_rx_s;
            end
            if (w_sc_mid) begin
                r_vote1 <= r_rx_s;
            end

            case (r_state)
                c_ST_IDLE: begin
                    r_bit_idx  <= '0;
                    r_stop_idx <= 1'b0;
                    r_stop_err <= 1'b0;
                end
                c_ST_DATA: begin
                    if (w_sc_dec) begin
                        r_shift <= {w_bit, r_shift[DATA_BITS-1:1]};
                    end
                    if (w_sc_last) begin
                        r_bit_idx <= r_bit_idx + c_IDX_W'(1);
                    end
                end
                c_ST_PAR: begin
                    if (w_sc_dec) begin
                        r_par_bit <= w_bit;
                    end
                end
                c_ST_STOP: begin
                    if (w_sc_dec) begin
                        r_stop_err <= w_stop_err;
                    end
                    if (w_sc_last) begin
                        r_stop_idx <= r_stop_idx + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // One-entry holding register with valid/ready handshake
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (w_frame_done) begin
                // A consumer draining the old frame this cycle frees the slot.
                if (!rx_valid || rx_ready) begin
                    rx_data    <= r_shift;
                    rx_valid   <= 1'b1;
                    parity_err <= w_par_err;
                    frame_err  <= w_stop_err;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

    assign busy = (r_state != c_ST_IDLE);

endmodule
`default_nettype wire
